// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer slice: fetch FSM state
//   encodings, the default reset PC and a PC alignment helper.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    // Default architectural PC after reset.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Fetch FSM states (3-bit encodings).
    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_VALID = 3'd3,
        FETCH_ERR   = 3'd4
    } fetch_state_e;

    // Instructions are word aligned; any set bit in [1:0] is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the fetch sequencer's bus signals.
//   Instruction-memory side : imem_req, imem_addr, imem_gnt, imem_rvalid,
//                             imem_rdata
//   Core/decode side        : halt, inst_valid, inst, inst_pc, commit, npc,
//                             misalign_err
//   modport master : view of the fetch sequencer itself
//   modport slave  : view of the surrounding core + instruction memory
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            halt;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            commit;
    logic [XLEN-1:0] npc;
    logic            misalign_err;

    modport master (
        input  halt,
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  commit,
        input  npc,
        output misalign_err
    );

    modport slave (
        output halt,
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output commit,
        output npc,
        input  misalign_err
    );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pc_reg
//   Architectural PC register with asynchronous active-low reset to RESET_PC
//   and a load enable.
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   load_en in   1     1 = capture pc_d on the next edge
//   pc_d    in   XLEN  value to load
//   pc_q    out  XLEN  current PC
// -----------------------------------------------------------------------------
module fetch_sequencer_pc_reg #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_q
);

    // PC storage; holds its value unless a load is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_en) begin
            pc_q <= pc_d;
        end else begin
            pc_q <= pc_q;
        end
    end

endmodule : fetch_sequencer_pc_reg

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the architectural PC and sequences instruction fetch: one outstanding
//   imem request at a time (req/gnt, then rvalid), holds the returned word for
//   decode until the core commits, then loads the next PC from the NPC unit.
//   A misaligned committed next-PC parks the sequencer in a terminal error
//   state until reset.
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   bus    master modport of fetch_sequencer_if (imem + core signals)
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_d;
    logic            misalign_err_q;
    logic            misalign_err_d;
    logic            pc_load_s;
    logic [XLEN-1:0] pc_q;

    fetch_sequencer_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (pc_load_s),
        .pc_d    (bus.npc),
        .pc_q    (pc_q)
    );

    // Next-state, instruction capture and error/PC-load decisions.
    // gnt/rvalid/commit are only looked at in the state that expects them,
    // so stray strobes (e.g. a response from before a reset) are dropped.
    always_comb begin
        state_d        = state_q;
        inst_d         = inst_q;
        misalign_err_d = misalign_err_q;
        pc_load_s      = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (!bus.halt) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (bus.imem_gnt) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d  = bus.imem_rdata;
                    state_d = FETCH_VALID;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_VALID: begin
                if (bus.commit) begin
                    if (is_misaligned(bus.npc[1:0])) begin
                        // Keep pc at the faulting instruction for debug.
                        misalign_err_d = 1'b1;
                        state_d        = FETCH_ERR;
                    end else begin
                        pc_load_s = 1'b1;
                        state_d   = FETCH_IDLE;
                    end
                end else begin
                    state_d = FETCH_VALID;
                end
            end
            FETCH_ERR: begin
                state_d = FETCH_ERR;
            end
            default: begin
                // Unreachable encodings fall into the safe terminal state.
                state_d = FETCH_ERR;
            end
        endcase
    end

    // State, instruction word and sticky error flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FETCH_IDLE;
            inst_q         <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            inst_q         <= inst_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Outputs come straight from flops or from a decode of the state flop.
    assign bus.imem_req     = (state_q == FETCH_REQ);
    assign bus.imem_addr    = pc_q;
    assign bus.inst_valid   = (state_q == FETCH_VALID);
    assign bus.inst         = inst_q;
    assign bus.inst_pc      = pc_q;
    assign bus.misalign_err = misalign_err_q;

endmodule : fetch_sequencer
